// File: rtl/toy_bus_arb_node_itcm_ack_rr_if.sv
// rtl/toy_bus_arb_node_itcm_ack_rr_if.sv - ToyBusAck valid/ready channel carrying one ack payload
interface toy_bus_arb_node_itcm_ack_rr_if #(
  parameter int DATA_W = 256,
  parameter int SB_W   = 10,
  parameter int ID_W   = 4
);
  logic              vld;
  logic              rdy;
  logic              opcode;
  logic [DATA_W-1:0] data;
  logic [SB_W-1:0]   sideband;
  logic [ID_W-1:0]   src_id;
  logic [ID_W-1:0]   tgt_id;

  modport master (
    output vld, opcode, data, sideband, src_id, tgt_id,
    input  rdy
  );

  modport slave (
    input  vld, opcode, data, sideband, src_id, tgt_id,
    output rdy
  );
endinterface

// File: rtl/toy_bus_arb_node_itcm_ack_rr.sv
// rtl/toy_bus_arb_node_itcm_ack_rr.sv - 2:1 round-robin ack merge with a DEPTH-entry output FIFO
module toy_bus_arb_node_itcm_ack_rr #(
  parameter int DATA_W = 256,
  parameter int SB_W   = 10,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  toy_bus_arb_node_itcm_ack_rr_if.slave         in0_if,
  toy_bus_arb_node_itcm_ack_rr_if.slave         in1_if,
  toy_bus_arb_node_itcm_ack_rr_if.master        out_if
);
  localparam int PW = 1 + DATA_W + SB_W + 2 * ID_W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          rr_q, rr_d;

  logic [PW-1:0] pay0, pay1, head;
  logic          full, sel0, sel1, rdy0, rdy1, push, pop, out_vld;

  assign pay0 = {in0_if.opcode, in0_if.data, in0_if.sideband, in0_if.src_id, in0_if.tgt_id};
  assign pay1 = {in1_if.opcode, in1_if.data, in1_if.sideband, in1_if.src_id, in1_if.tgt_id};

  assign full = (count_q == CW'(DEPTH));
  assign sel0 = in0_if.vld && (!in1_if.vld || !rr_q);
  assign sel1 = in1_if.vld && (!in0_if.vld ||  rr_q);
  // rst gating keeps both readies low while reset is held, independent of the clock
  assign rdy0 = sel0 && !full && !rst;
  assign rdy1 = sel1 && !full && !rst;
  assign in0_if.rdy = rdy0;
  assign in1_if.rdy = rdy1;

  assign push    = rdy0 || rdy1;
  assign out_vld = (count_q != '0);
  assign pop     = out_vld && out_if.rdy;

  assign head       = mem_q[rptr_q];
  assign out_if.vld = out_vld;
  assign {out_if.opcode, out_if.data, out_if.sideband, out_if.src_id, out_if.tgt_id} = head;

  always_comb begin
    count_d = count_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    rr_d    = rr_q;
    if (push) begin
      wptr_d = wptr_q + AW'(1);
      rr_d   = ~rdy1;
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      rr_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      rr_q    <= rr_d;
      if (push) begin
        mem_q[wptr_q] <= rdy1 ? pay1 : pay0;
      end
    end
  end
endmodule

// File: tb/tb_toy_bus_arb_node_itcm_ack_rr.sv
// tb/tb_toy_bus_arb_node_itcm_ack_rr.sv - directed bench with arbitration model and payload scoreboard
module tb_toy_bus_arb_node_itcm_ack_rr;
  localparam int DATA_W = 256;
  localparam int SB_W   = 10;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 2;
  localparam int PW     = 1 + DATA_W + SB_W + 2 * ID_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  toy_bus_arb_node_itcm_ack_rr_if #(.DATA_W(DATA_W), .SB_W(SB_W), .ID_W(ID_W)) in0_bus ();
  toy_bus_arb_node_itcm_ack_rr_if #(.DATA_W(DATA_W), .SB_W(SB_W), .ID_W(ID_W)) in1_bus ();
  toy_bus_arb_node_itcm_ack_rr_if #(.DATA_W(DATA_W), .SB_W(SB_W), .ID_W(ID_W)) out_bus ();

  toy_bus_arb_node_itcm_ack_rr #(.DATA_W(DATA_W), .SB_W(SB_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .in0_if (in0_bus),
    .in1_if (in1_bus),
    .out_if (out_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] q[$];
  int            gh[$];
  int            mcount = 0;
  logic          mrr = 1'b0;
  logic          acc0 = 1'b0, acc1 = 1'b0;
  logic          m_full, e0, e1;
  logic [PW-1:0] p_in0, p_in1, p_out;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pay(input logic op, input logic [DATA_W-1:0] d,
                                        input logic [SB_W-1:0] sb, input logic [ID_W-1:0] s,
                                        input logic [ID_W-1:0] t);
    return {op, d, sb, s, t};
  endfunction

  function automatic logic [PW-1:0] rnd_pay();
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < (PW + 31) / 32; i++) r = (r << 32) | PW'($urandom);
    return r;
  endfunction

  task automatic drv(input int k, input logic v, input logic [PW-1:0] p);
    if (k == 0) begin
      {in0_bus.opcode, in0_bus.data, in0_bus.sideband, in0_bus.src_id, in0_bus.tgt_id} = p;
      in0_bus.vld = v;
    end else begin
      {in1_bus.opcode, in1_bus.data, in1_bus.sideband, in1_bus.src_id, in1_bus.tgt_id} = p;
      in1_bus.vld = v;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model, evaluated mid-cycle when inputs and DUT outputs are settled
  always @(negedge clk) begin
    p_in0 = {in0_bus.opcode, in0_bus.data, in0_bus.sideband, in0_bus.src_id, in0_bus.tgt_id};
    p_in1 = {in1_bus.opcode, in1_bus.data, in1_bus.sideband, in1_bus.src_id, in1_bus.tgt_id};
    p_out = {out_bus.opcode, out_bus.data, out_bus.sideband, out_bus.src_id, out_bus.tgt_id};
    if (rst) begin
      mcount = 0;
      mrr    = 1'b0;
      q.delete();
      acc0   = 1'b0;
      acc1   = 1'b0;
      chk("rst_in0_rdy", PW'(in0_bus.rdy), '0);
      chk("rst_in1_rdy", PW'(in1_bus.rdy), '0);
      chk("rst_out_vld", PW'(out_bus.vld), '0);
      chk("rst_out_pay", p_out, '0);
    end else begin
      m_full = (mcount == DEPTH);
      e0 = in0_bus.vld && (!in1_bus.vld || !mrr) && !m_full;
      e1 = in1_bus.vld && (!in0_bus.vld ||  mrr) && !m_full;
      chk("in0_rdy", PW'(in0_bus.rdy), PW'(e0));
      chk("in1_rdy", PW'(in1_bus.rdy), PW'(e1));
      chk("out_vld", PW'(out_bus.vld), PW'(mcount != 0));
      if (in0_bus.vld && in0_bus.rdy) gh.push_back(0);
      else if (in1_bus.vld && in1_bus.rdy) gh.push_back(1);
      if (mcount != 0) begin
        chk("head_payload", p_out, q[0]);
        if (out_bus.rdy) begin
          void'(q.pop_front());
          mcount--;
        end
      end
      if (e0) q.push_back(p_in0);
      else if (e1) q.push_back(p_in1);
      if (e0 || e1) begin
        mrr = e0;
        mcount++;
      end
      acc0 = e0;
      acc1 = e1;
    end
  end

  initial begin
    logic [PW-1:0] pa, pb, pt;
    logic [DATA_W-1:0] a5;
    int budget;

    out_bus.rdy = 1'b0;
    drv(0, 1'b0, '0);
    drv(1, 1'b0, '0);
    rst = 1'b1;
    tick(2);
    chk("reset_out_vld", PW'(out_bus.vld), '0);
    chk("reset_out_data", PW'(out_bus.data), '0);
    rst = 1'b0;
    tick(1);

    // single ack from in0
    out_bus.rdy = 1'b1;
    a5 = {32{8'hA5}};
    pa = pay(1'b1, a5, '0, 4'd3, 4'd0);
    drv(0, 1'b1, pa);
    #1;
    chk("t1_in0_rdy", PW'(in0_bus.rdy), PW'(1));
    chk("t1_in1_rdy", PW'(in1_bus.rdy), '0);
    tick(1);
    drv(0, 1'b0, '0);
    chk("t1_out_vld", PW'(out_bus.vld), PW'(1));
    chk("t1_out_pay", {out_bus.opcode, out_bus.data, out_bus.sideband, out_bus.src_id, out_bus.tgt_id}, pa);
    tick(2);

    // both valid for 6 cycles from a fresh reset: strict alternation starting with in0
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    gh.delete();
    out_bus.rdy = 1'b1;
    pa = rnd_pay();
    pb = rnd_pay();
    drv(0, 1'b1, pa);
    drv(1, 1'b1, pb);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (acc0) begin pa = rnd_pay(); drv(0, 1'b1, pa); end
      if (acc1) begin pb = rnd_pay(); drv(1, 1'b1, pb); end
    end
    drv(0, 1'b0, '0);
    drv(1, 1'b0, '0);
    chk("t2_grant_count", PW'(gh.size()), PW'(6));
    for (int i = 0; i < 6 && i < gh.size(); i++) chk("t2_grant_order", PW'(gh[i]), PW'(i % 2));
    tick(2);

    // stalled output fills the FIFO, then drains in order
    out_bus.rdy = 1'b0;
    pa = rnd_pay();
    pb = rnd_pay();
    drv(0, 1'b1, pa);
    drv(1, 1'b1, pb);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (acc0) begin pa = rnd_pay(); drv(0, 1'b1, pa); end
      if (acc1) begin pb = rnd_pay(); drv(1, 1'b1, pb); end
    end
    #1;
    chk("t3_full_in0_rdy", PW'(in0_bus.rdy), '0);
    chk("t3_full_in1_rdy", PW'(in1_bus.rdy), '0);
    chk("t3_full_out_vld", PW'(out_bus.vld), PW'(1));
    drv(0, 1'b0, '0);
    drv(1, 1'b0, '0);
    tick(2);
    out_bus.rdy = 1'b1;
    tick(3);

    // steady state: one push and one pop per cycle, pointers wrapping
    pa = rnd_pay();
    drv(0, 1'b1, pa);
    for (int i = 0; i < 21; i++) begin
      tick(1);
      if (acc0) begin pa = rnd_pay(); drv(0, 1'b1, pa); end
    end
    drv(0, 1'b0, '0);
    chk("t4_count_one", PW'(q.size()), PW'(1));
    tick(2);

    // in1 alone three times, then the first contention goes to in0
    pb = rnd_pay();
    drv(1, 1'b1, pb);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (acc1) begin pb = rnd_pay(); drv(1, 1'b1, pb); end
    end
    pa = rnd_pay();
    drv(0, 1'b1, pa);
    #1;
    chk("t5_contend_in0", PW'(in0_bus.rdy), PW'(1));
    chk("t5_contend_in1", PW'(in1_bus.rdy), '0);
    tick(1);
    drv(0, 1'b0, '0);
    drv(1, 1'b0, '0);
    tick(3);

    // reset while the FIFO holds two stalled entries
    out_bus.rdy = 1'b0;
    pa = rnd_pay();
    drv(0, 1'b1, pa);
    tick(1);
    pa = rnd_pay();
    drv(0, 1'b1, pa);
    tick(1);
    pa = rnd_pay();
    drv(0, 1'b1, pa);
    chk("t6_full_out_vld", PW'(out_bus.vld), PW'(1));
    rst = 1'b1;
    #1;
    chk("t6_rst_out_vld", PW'(out_bus.vld), '0);
    chk("t6_rst_in0_rdy", PW'(in0_bus.rdy), '0);
    tick(2);
    rst = 1'b0;
    drv(0, 1'b0, '0);
    tick(1);
    out_bus.rdy = 1'b1;
    pt = rnd_pay();
    drv(0, 1'b1, pt);
    tick(1);
    drv(0, 1'b0, '0);
    chk("t6_after_vld", PW'(out_bus.vld), PW'(1));
    chk("t6_after_pay", {out_bus.opcode, out_bus.data, out_bus.sideband, out_bus.src_id, out_bus.tgt_id}, pt);
    tick(1);
    chk("t6_once", PW'(out_bus.vld), '0);

    budget = 50;
    while (q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    chk("drain_empty", PW'(q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
